// File: rtl/lsmitll_sched_pkg.sv
// lsmitll_sched_pkg: scheduler state encoding and round-robin pick helper
package lsmitll_sched_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, FAULT} state_t;
    function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [7:0] g;
        logic [2:0] j;
        g = '0;
        for (int i = 7; i >= 0; i--) begin
            j = ptr + 3'(i);
            if (req[j]) g = 8'b1 << j;
        end
        return g;
    endfunction
endpackage

// File: rtl/lsmitll_toggle_rx.sv
// lsmitll_toggle_rx: toggle-edge detector with seen flag and double-edge error
module lsmitll_toggle_rx (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic x,
    input  logic clr,
    input  logic pend_zero,
    output logic tog,
    output logic seen,
    output logic err
);
    logic prev;
    assign tog = x ^ prev;
    assign err = tog && (seen || pend_zero);
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
            seen <= 1'b0;
        end else if (en) begin
            prev <= x;
            seen <= clr ? 1'b0 : (tog ? 1'b1 : seen);
        end
    end
endmodule

// File: rtl/lsmitll_splitt_sched.sv
// lsmitll_splitt_sched: shares one LSmitll splitter input among requesters with hold-off and return checking
module lsmitll_splitt_sched
    import lsmitll_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int HOLDOFF  = 3,
    parameter int MAX_PEND = 3,
    parameter int TIMEOUT  = 8,
    localparam int PW      = $clog2(MAX_PEND + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             a_o,
    input  logic             q_i,
    input  logic             m_i,
    output logic [PW-1:0]    pend,
    output logic             busy,
    output logic             fault
);
    state_t st, st_nxt;
    logic [3:0] hcnt, hcnt_nxt;
    logic [2:0] ptr, ptr_nxt, idx;
    logic [7:0] tcnt, tcnt_nxt, pick;
    logic [PW-1:0] pend_nxt;
    logic en, issue, done, tmo, fault_set;
    logic q_tog, q_seen, q_err, m_tog, m_seen, m_err;

    assign en = st != FAULT;

    lsmitll_toggle_rx u_q (
        .clk(clk), .rst(rst), .en(en), .x(q_i), .clr(done), .pend_zero(pend == '0),
        .tog(q_tog), .seen(q_seen), .err(q_err)
    );
    lsmitll_toggle_rx u_m (
        .clk(clk), .rst(rst), .en(en), .x(m_i), .clr(done), .pend_zero(pend == '0),
        .tog(m_tog), .seen(m_seen), .err(m_err)
    );

    // a pulse completes once both outputs have returned one edge, possibly in the same cycle
    assign done = en && !(q_err || m_err) && (q_seen || q_tog) && (m_seen || m_tog) && (q_tog || m_tog);
    assign tcnt_nxt = (pend == '0 || done) ? 8'd0 : tcnt + 8'd1;
    assign tmo = tcnt_nxt == 8'(TIMEOUT);
    assign fault_set = en && (q_err || m_err || tmo);
    assign issue = st == IDLE && |req && pend < PW'(MAX_PEND) && !fault_set;
    assign pick = rr_pick(8'(req), ptr);

    always_comb begin
        idx = '0;
        for (int i = 0; i < 8; i++) if (pick[i]) idx = 3'(i);
    end

    assign ptr_nxt = issue ? ((idx == 3'(N_REQ - 1)) ? 3'd0 : idx + 3'd1) : ptr;
    assign hcnt_nxt = issue ? 4'(HOLDOFF - 1) : (st == HOLD ? hcnt - 4'd1 : hcnt);
    assign pend_nxt = pend + PW'(issue) - PW'(done);

    always_comb begin
        st_nxt = st;
        if (fault_set || st == FAULT) st_nxt = FAULT;
        else if (issue) st_nxt = (HOLDOFF > 1) ? HOLD : IDLE;
        else if (st == HOLD && hcnt == 4'd1) st_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= IDLE;
            hcnt <= '0;
            ptr  <= '0;
            tcnt <= '0;
            pend <= '0;
            gnt  <= '0;
            a_o  <= 1'b0;
        end else begin
            st   <= st_nxt;
            hcnt <= hcnt_nxt;
            ptr  <= ptr_nxt;
            tcnt <= en ? tcnt_nxt : tcnt;
            pend <= pend_nxt;
            gnt  <= issue ? pick[N_REQ-1:0] : '0;
            a_o  <= a_o ^ issue;
        end
    end

    assign busy  = hcnt != '0 || pend != '0;
    assign fault = st == FAULT;
endmodule
